// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART global settings (UartGlobalPkg) plus the receive FSM state type.
package UartGlobalPkg;
  localparam int DATA_WIDTH = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;

  typedef enum logic {EVEN_PARITY = 1'b0, ODD_PARITY = 1'b1} PARITY_TYPE_E;
  typedef enum logic [1:0] {ONE_BIT = 2'd1, TWO_BIT = 2'd2} STOP_BIT_E;
  typedef enum logic [3:0] {FIVE_BIT = 4'd5, SIX_BIT = 4'd6, SEVEN_BIT = 4'd7, EIGHT_BIT = 4'd8} DATA_TYPE_E;
  typedef enum int {OVERSAMPLE_13 = 13, OVERSAMPLE_16 = 16} OVER_SAMPLING_E;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} UART_RX_STATE_E;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side character holding register handshake (valid/ready plus status).
interface uart_rx_deserializer_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] rxData;
  logic rxValid;
  logic rxReady;
  logic parityError;
  logic framingError;
  logic overrunError;

  modport master (output rxData, rxValid, parityError, framingError, overrunError, input rxReady);
  modport slave (input rxData, rxValid, parityError, framingError, overrunError, output rxReady);
endinterface

// File: rtl/uart_rx_deserializer_baud_tick_gen.sv
// Oversample tick generator: one-clk tick every max(divisor,1) clocks, restartable.
module uart_baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] last;

  assign last = (divisor == '0) ? '0 : divisor - 1'b1;
  // >= so a divisor lowered mid-count still wraps promptly
  assign tick = (cnt >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || tick)  cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver with valid/ready holding register.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each bit centre.
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronized line
// START  | confirming the start bit at mid-bit
// DATA   | shifting in data bits LSB first
// PARITY | sampling and checking the parity bit
// STOP   | sampling one or two stop bits, completes the frame
module uart_rx_deserializer #(
  parameter int DATA_WIDTH   = UartGlobalPkg::DATA_WIDTH,
  parameter int OVERSAMPLING = 16,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] baudDivisor,
  input  logic [3:0]           dataType,
  input  logic                 parityEnable,
  input  logic                 parityType,
  input  logic [1:0]           stopBits,
  uart_rx_deserializer_if.master rx_if
);
  import UartGlobalPkg::*;

  localparam int OS_W  = $clog2(OVERSAMPLING + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_LAG = 1;
`else
  localparam int VOTE_LAG = 0;
`endif
  localparam logic [OS_W-1:0] START_DEC = OS_W'(OVERSAMPLING / 2 - 1 + VOTE_LAG);
  localparam logic [OS_W-1:0] BIT_DEC   = OS_W'(OVERSAMPLING - 1);

  logic [1:0] rst_sync;
  logic rst_i_n;
  logic rx_meta, rx_s, rx_s_d;
  logic tick, tick_clear;
  UART_RX_STATE_E state, state_nxt;
  logic [OS_W-1:0] os_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic stop_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic perr_reg, ferr_reg;
  logic [3:0] cfg_len;
  logic cfg_par_en, cfg_par_type, cfg_two_stop;
  logic start_edge, at_dec, bit_val, last_data, last_stop, frame_done, frame_ferr;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic rx_valid_q, perr_q, ferr_q, ovr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) {rx_meta, rx_s, rx_s_d} <= 3'b111;
    else          {rx_meta, rx_s, rx_s_d} <= {rx, rx_meta, rx_s};
  end

  uart_baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk(clk), .rst_n(rst_i_n), .clear(tick_clear), .divisor(baudDivisor), .tick(tick)
  );

  assign start_edge = rx_s_d & ~rx_s;
  assign last_data  = (int'(bit_cnt) + 1 == int'(cfg_len));
  assign last_stop  = !cfg_two_stop || stop_cnt;

  // Decision tick lags the centre by one when voting so the third sample exists.
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n)  hist <= 2'b11;
    else if (tick) hist <= {hist[0], rx_s};
  end
  assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    at_dec = 1'b0;
    if (tick) at_dec = (state == START) ? (os_cnt == START_DEC) : (os_cnt == BIT_DEC);
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (at_dec) state_nxt = (bit_val == START_BIT) ? DATA : IDLE;
      DATA:    if (at_dec && last_data) state_nxt = cfg_par_en ? PARITY : STOP;
      PARITY:  if (at_dec) state_nxt = STOP;
      STOP:    if (at_dec && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tick_clear = (state == IDLE) && start_edge;
    frame_done = (state == STOP) && at_dec && last_stop;
    frame_ferr = ferr_reg | (bit_val != STOP_BIT);
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      os_cnt <= '0; bit_cnt <= '0; stop_cnt <= 1'b0; shift_reg <= '0;
      perr_reg <= 1'b0; ferr_reg <= 1'b0;
      cfg_len <= EIGHT_BIT; cfg_par_en <= 1'b0; cfg_par_type <= 1'b0; cfg_two_stop <= 1'b0;
    end else begin
      if (state == IDLE)  os_cnt <= '0;
      else if (tick)      os_cnt <= at_dec ? '0 : os_cnt + 1'b1;
      unique case (state)
        IDLE: if (start_edge) begin
          bit_cnt <= '0; stop_cnt <= 1'b0; shift_reg <= '0;
          perr_reg <= 1'b0; ferr_reg <= 1'b0;
          cfg_len <= (dataType >= FIVE_BIT && dataType <= EIGHT_BIT) ? dataType : EIGHT_BIT;
          cfg_par_en <= parityEnable;
          cfg_par_type <= parityType;
          cfg_two_stop <= (stopBits == TWO_BIT);
        end
        DATA: if (at_dec) begin
          shift_reg[bit_cnt] <= bit_val;
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: if (at_dec) perr_reg <= (^shift_reg ^ bit_val) != cfg_par_type;
        STOP: if (at_dec) begin
          ferr_reg <= frame_ferr;
          stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      rx_data_q <= '0; rx_valid_q <= 1'b0; perr_q <= 1'b0; ferr_q <= 1'b0; ovr_q <= 1'b0;
    end else begin
      ovr_q <= frame_done && rx_valid_q && !rx_if.rxReady;
      if (frame_done && (!rx_valid_q || rx_if.rxReady)) begin
        rx_data_q  <= shift_reg;
        rx_valid_q <= 1'b1;
        perr_q     <= perr_reg;
        ferr_q     <= frame_ferr;
      end else if (rx_valid_q && rx_if.rxReady) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rxData       = rx_data_q;
  assign rx_if.rxValid      = rx_valid_q;
  assign rx_if.parityError  = perr_q;
  assign rx_if.framingError = ferr_q;
  assign rx_if.overrunError = ovr_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_deserializer;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [3:0] data_type = 4'd8;
  logic par_en = 1'b0;
  logic par_type = 1'b0;
  logic [1:0] stop_bits = 2'd1;
  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [7:0] data; logic perr; logic ferr;} item_t;
  item_t got_q[$];
  int ovr_cnt = 0;
  int valid_cycles = 0;

  uart_rx_deserializer_if #(.DATA_WIDTH(8)) rx_if ();

  uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLING(OS), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .baudDivisor(baud_div), .dataType(data_type),
    .parityEnable(par_en), .parityType(par_type), .stopBits(stop_bits), .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_if.rxValid && rx_if.rxReady)
        got_q.push_back({rx_if.rxData, rx_if.parityError, rx_if.framingError});
      if (rx_if.overrunError) ovr_cnt++;
      if (rx_if.rxValid) valid_cycles++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    step(n);
  endtask

  function automatic int eff_len(input logic [3:0] dt);
    return (dt >= 4'd5 && dt <= 4'd8) ? int'(dt) : 8;
  endfunction

  function automatic int eff_stops(input logic [1:0] sb);
    return (sb == 2'd2) ? 2 : 1;
  endfunction

  function automatic int bit_clks();
    return OS * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  function automatic item_t model(input logic [7:0] d, input logic pbit, input logic [1:0] stopv);
    item_t r;
    int len = eff_len(data_type);
    int ones = 0;
    r.data = '0;
    for (int i = 0; i < len; i++) begin
      r.data[i] = d[i];
      ones += int'(d[i]);
    end
    r.perr = par_en && (((ones + int'(pbit)) % 2) != int'(par_type));
    r.ferr = (stopv[0] == 1'b0) || (eff_stops(stop_bits) == 2 && stopv[1] == 1'b0);
    return r;
  endfunction

  task automatic set_cfg(input int div, input int dt, input logic pe, input logic pt, input int sb);
    baud_div = 16'(div); data_type = 4'(dt); par_en = pe; par_type = pt; stop_bits = 2'(sb);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic [1:0] stopv);
    int bc = bit_clks();
    drive_bit(1'b0, bc);
    for (int i = 0; i < eff_len(data_type); i++) drive_bit(d[i], bc);
    if (par_en) drive_bit(pbit, bc);
    for (int i = 0; i < eff_stops(stop_bits); i++) drive_bit(stopv[i], bc);
    drive_bit(1'b1, 2 * bc);
  endtask

  task automatic expect_frame(input string tag, input item_t exp);
    item_t got;
    int n = 0;
    while (got_q.size() == 0 && n < 400) begin
      step(1);
      n++;
    end
    check_val({tag, "_count"}, got_q.size(), 1);
    if (got_q.size() != 0) begin
      got = got_q.pop_front();
      check_val({tag, "_data"}, got.data, exp.data);
      check_val({tag, "_perr"}, got.perr, exp.perr);
      check_val({tag, "_ferr"}, got.ferr, exp.ferr);
    end
    got_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_data"}, rx_if.rxData, 0);
    check_val({tag, "_valid"}, rx_if.rxValid, 0);
    check_val({tag, "_perr"}, rx_if.parityError, 0);
    check_val({tag, "_ferr"}, rx_if.framingError, 0);
    check_val({tag, "_ovr"}, rx_if.overrunError, 0);
  endtask

  initial begin
    int v0, ov0, bc;
    logic [7:0] d;
    logic pbit;
    logic [1:0] stopv;
    rx_if.rxReady = 1'b1;
    step(3);
    check_idle_outputs("reset");
    reset = 1'b1;
    step(5);

    set_cfg(4, 8, 1'b0, 1'b0, 1);
    v0 = valid_cycles;
    send_frame(8'hA5, 1'b0, 2'b11);
    expect_frame("8n1", model(8'hA5, 1'b0, 2'b11));
    check_val("8n1_valid_cycles", valid_cycles - v0, 1);

    set_cfg(2, 7, 1'b1, 1'b0, 2);
    send_frame(8'h35, 1'b0, 2'b11);
    expect_frame("7e2_good", model(8'h35, 1'b0, 2'b11));
    send_frame(8'h35, 1'b1, 2'b11);
    expect_frame("7e2_bad", model(8'h35, 1'b1, 2'b11));

    set_cfg(2, 8, 1'b1, 1'b1, 1);
    send_frame(8'h00, 1'b1, 2'b00);
    expect_frame("8o1_ferr", model(8'h00, 1'b1, 2'b00));

    set_cfg(4, 8, 1'b0, 1'b0, 1);
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 2 * bit_clks());
    check_val("glitch_none", got_q.size(), 0);
    send_frame(8'h5A, 1'b0, 2'b11);
    expect_frame("after_glitch", model(8'h5A, 1'b0, 2'b11));

    set_cfg(2, 8, 1'b0, 1'b0, 1);
    rx_if.rxReady = 1'b0;
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 2'b11);
    check_val("ovr_hold_valid", rx_if.rxValid, 1);
    check_val("ovr_hold_data1", rx_if.rxData, 32'h11);
    send_frame(8'h22, 1'b0, 2'b11);
    check_val("ovr_hold_data2", rx_if.rxData, 32'h11);
    check_val("ovr_pulses", ovr_cnt - ov0, 1);
    rx_if.rxReady = 1'b1;
    step(2);
    check_val("ovr_valid_drop", rx_if.rxValid, 0);
    expect_frame("ovr_drain", model(8'h11, 1'b0, 2'b11));

    set_cfg(2, 8, 1'b0, 1'b0, 1);
    bc = bit_clks();
    drive_bit(1'b0, bc);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, bc);
    reset = 1'b0;
    step(3);
    check_idle_outputs("mid_reset");
    rx = 1'b1;
    reset = 1'b1;
    step(10);
    got_q.delete();
    send_frame(8'h0F, 1'b0, 2'b11);
    expect_frame("post_reset", model(8'h0F, 1'b0, 2'b11));

    for (int k = 0; k < 20; k++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(3, 10), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3));
      d = 8'($urandom);
      pbit = 1'($urandom);
      stopv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send_frame(d, pbit, stopv);
      expect_frame($sformatf("rand%0d", k), model(d, pbit, stopv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- RTL UART receiver that directly consumes the serial line driven by the UART transmitter/BFM, using the shared UART global package settings.
- Oversamples `rx`, detects the start bit, and shifts in 5–8 data bits, optional parity and 1–2 stop bits.
- Presents each received character on a valid/ready output holding register.
- Acts as the DUT-side receive stage the Rx agent monitors against.

Parameters:
- DATA_WIDTH, 8, maximum character width; matches the package DATA_WIDTH.
- OVERSAMPLING, 16, oversample ticks per bit; legal values 16 and 13 (OVER_SAMPLING_E).
- DIV_WIDTH, 16, width of the baud divisor port.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line; idle high.
- baudDivisor  input  DIV_WIDTH  clk cycles per oversample tick; 0 is treated as 1.
- dataType  input  4  character length 5..8 (DATA_TYPE_E); values outside 5..8 are treated as 8.
- parityEnable  input  1  parity bit present.
- parityType  input  1  0 = EVEN_PARITY, 1 = ODD_PARITY.
- stopBits  input  2  1 = ONE_BIT, 2 = TWO_BIT; other values are treated as 1.
- rxData  output  DATA_WIDTH  received character, LSB-aligned, upper bits zero.
- rxValid  output  1  rxData holds an unconsumed character.
- rxReady  input  1  consumer accepts rxData when rxValid && rxReady.
- parityError  output  1  parity status of the held character; valid while rxValid.
- framingError  output  1  stop-bit status of the held character; valid while rxValid.
- overrunError  output  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async assert, sync deassert internally):
  - synchronizer flops = 1; tick counter = 0; FSM = IDLE.
  - rxData = 0, rxValid = 0, parityError = 0, framingError = 0, overrunError = 0.
- Input path:
  - 2-flop synchronizer on rx; all logic uses the synchronized value rxS.
- Tick generator:
  - Counts 0..max(baudDivisor,1)-1 and pulses `tick` for one clk at wrap.
  - Free-running; restarts from 0 when the FSM leaves IDLE.
- Configuration inputs are sampled once at the IDLE->START transition and held for the whole frame.
- FSM states and transitions:
  - IDLE: rxS falling edge -> START; oversample counter osCnt = 0.
  - START: on each tick osCnt++. At osCnt == OVERSAMPLING/2-1 (mid-bit):
    - rxS = 0 -> DATA, osCnt = 0, bitCnt = 0.
    - rxS = 1 -> glitch, back to IDLE with no output.
  - DATA: sample rxS when osCnt == OVERSAMPLING-1 (centre of each bit); shift LSB-first into shiftReg[bitCnt].
    - After dataType bits: -> PARITY if parityEnable, else -> STOP.
  - PARITY: sample the parity bit.
    - Error if XOR(data bits, parity bit) != parityType; i.e. even requires XOR = 0, odd requires XOR = 1.
  - STOP: sample each stop bit (stopBits of them); any sampled 0 sets framingError for the frame.
    - After the first stop sample, a 0 still ends the frame (no break detect).
    - Frame completes at the centre of the last stop bit -> IDLE. A new start edge is accepted from the next clk.
- Frame completion:
  - rxValid == 0, or rxValid && rxReady in the same cycle: load rxData/parityError/framingError and set rxValid = 1 on the next clk.
  - rxValid == 1 and !rxReady: the new frame is discarded, the held character is kept, and overrunError pulses for 1 clk.
- Handshake:
  - rxValid clears the clk after rxValid && rxReady unless a completion loads in the same cycle.
  - rxData is stable while rxValid && !rxReady.
- Latency: rxValid rises 1 clk after the tick that samples the centre of the last stop bit, plus 2 synchronizer cycles from the line.
- Reset mid-frame: the frame is aborted and all outputs return to reset values.
- rxS staying at 0 forever: the frame completes with framingError = 1, then IDLE waits for a rising then falling edge.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: every bit sample (start, data, parity, stop) is the 2-of-3 majority of rxS at osCnt centre-1, centre and centre+1 ticks. The decision is taken at centre+1, so completion latency grows by 1 tick.
- Undefined: single sample at the centre tick.

Decomposition:
- Shared package UartGlobalPkg holds PARITY_TYPE_E, STOP_BIT_E, DATA_TYPE_E, OVER_SAMPLING_E, DATA_WIDTH, START_BIT and STOP_BIT.
- New package item: rx state enum UART_RX_STATE_E {IDLE, START, DATA, PARITY, STOP}.
- Sub-module: uart_baud_tick_gen, containing the divisor counter and tick output.

Test Plan:
- 8N1, baudDivisor = 4, OVERSAMPLING = 16, send 0xA5 with rxReady = 1 -> rxData = 0xA5, rxValid for 1 clk, parityError = 0, framingError = 0.
- 7E2, send 0x35 with parity bit 0 -> rxData = 0x35, parityError = 0; repeat with parity bit 1 -> parityError = 1.
- 8O1, stop bit driven 0 on byte 0x00 -> framingError = 1, rxData = 0x00.
- 3-clk low glitch on idle line -> no rxValid; a following 0x5A frame is received correctly.
- rxReady = 0, send 0x11 then 0x22 -> rxData stays 0x11, overrunError pulses once at the end of frame 2; assert rxReady -> rxValid drops.
- Assert reset during the DATA state of 0xFF, release, send 0x0F -> outputs are 0 during reset and only 0x0F is delivered.
